// File: rtl/fp_running_max.sv
// Streaming IEEE-754 maximum finder with argmax index, NaN-seen and index-overflow flags.
// Latency: the result is registered and valid one cycle after the beat carrying in_last.
// Backpressure: in_ready drops while the result is held, and returns the cycle after out_ready takes it.
module fp_running_max #(
  parameter int    BITS       = 16,
  parameter string PRECISION  = "HALF",
  parameter int    INDEX_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_max,
  output logic [INDEX_BITS-1:0] out_index,
  output logic                  out_nan,
  output logic                  out_ovf
);

  localparam int EXP_W = (PRECISION == "HALF")   ? 5 :
                         (PRECISION == "SINGLE") ? 8 : 11;
  localparam int MAN_W = BITS - 1 - EXP_W;

  // Canonical quiet NaN: positive sign, exponent all ones, mantissa MSB set
  localparam logic [BITS-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [INDEX_BITS-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                state_q;
  logic [BITS-1:0]       cand_q, cand_d;
  logic [INDEX_BITS-1:0] cand_idx_q, cand_idx_d;
  logic [INDEX_BITS-1:0] cnt_q;
  logic                  nan_q, nan_d;
  logic                  ovf_q, ovf_d;
  logic                  have_d;

  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [BITS-1:0]       out_max_q;
  logic [INDEX_BITS-1:0] out_index_q;
  logic                  out_nan_q;
  logic                  out_ovf_q;

  logic accept;
  logic elem_nan;
  logic take;

  function automatic logic is_nan(input logic [BITS-1:0] v);
    return (&v[BITS-2:MAN_W]) && (|v[MAN_W-1:0]);
  endfunction

  // Ordering of two non-NaN values; sign-magnitude so negatives compare reversed
  function automatic logic fp_gt(input logic [BITS-1:0] x, input logic [BITS-1:0] y);
    logic [BITS-2:0] mx;
    logic [BITS-2:0] my;
    logic            r;
    mx = x[BITS-2:0];
    my = y[BITS-2:0];
    if (mx == '0 && my == '0) begin
      r = 1'b0;
    end else if (x[BITS-1] != y[BITS-1]) begin
      r = ~x[BITS-1];
    end else if (!x[BITS-1]) begin
      r = (mx > my);
    end else begin
      r = (mx < my);
    end
    return r;
  endfunction

  // Candidate update for the beat on the inputs; ties keep the earlier index
  always_comb begin
    accept     = in_valid && in_ready_q;
    elem_nan   = is_nan(in_data);
    take       = accept && !elem_nan &&
                 ((state_q == S_EMPTY) || fp_gt(in_data, cand_q));
    cand_d     = take ? in_data : cand_q;
    cand_idx_d = take ? cnt_q : cand_idx_q;
    nan_d      = nan_q | (accept & elem_nan);
    // Counter about to wrap with more beats still to come: frame exceeds the index range
    ovf_d      = ovf_q | (accept && (cnt_q == IDX_MAX) && !in_last);
    have_d     = (state_q == S_ACCUM) || take;
  end

  // Frame state machine with registered handshake and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      cand_q      <= '0;
      cand_idx_q  <= '0;
      cnt_q       <= '0;
      nan_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_index_q <= '0;
      out_nan_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY, S_ACCUM: begin
          if (accept) begin
            cand_q     <= cand_d;
            cand_idx_q <= cand_idx_d;
            nan_q      <= nan_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_q + 1'b1;
            if (in_last) begin
              state_q     <= S_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_max_q   <= have_d ? cand_d : QNAN;
              out_index_q <= have_d ? cand_idx_d : '0;
              out_nan_q   <= nan_d;
              out_ovf_q   <= ovf_d;
            end else begin
              state_q <= have_d ? S_ACCUM : S_EMPTY;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_EMPTY;
            cand_q      <= '0;
            cand_idx_q  <= '0;
            cnt_q       <= '0;
            nan_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_index = out_index_q;
  assign out_nan   = out_nan_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fp_running_max.sv
// Bench for fp_running_max in half precision with a 2-bit index counter.
// Directed frames plus random frames scored against a real-valued reference model.
module tb_fp_running_max;
  localparam int IB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_max;
  logic [IB-1:0] out_index;
  logic          out_nan;
  logic          out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] frame_q[$];
  logic [15:0] m_max;
  int          m_idx;
  bit          m_nan;
  bit          m_ovf;

  fp_running_max #(.BITS(16), .PRECISION("HALF"), .INDEX_BITS(IB)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_index(out_index), .out_nan(out_nan), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Numeric value of a non-NaN half; infinities stand in as huge reals
  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    int  m;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31)     v = 1.0e30;
    else if (e == 0) v = real'(m) * (2.0 ** -24);
    else             v = real'(1024 + m) * (2.0 ** (e - 25));
    return h[15] ? -v : v;
  endfunction

  // Reference: first index of the numerically largest non-NaN element
  task automatic model();
    bit  have;
    real best;
    have  = 0;
    best  = 0.0;
    m_nan = 0;
    m_max = 16'h7E00;
    m_idx = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i][14:10] == 5'h1f && frame_q[i][9:0] != 0) begin
        m_nan = 1;
      end else if (!have || h2r(frame_q[i]) > best) begin
        have  = 1;
        best  = h2r(frame_q[i]);
        m_max = frame_q[i];
        m_idx = i % (1 << IB);
      end
    end
    m_ovf = frame_q.size() > (1 << IB);
  endtask

  task automatic send_beat(input logic [15:0] d, input bit last);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      check("beat_timeout", 64'(in_ready), 64'd1);
    end else begin
      check("no_early_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send frame_q, check the result one cycle after the last beat, hold, then release
  task automatic run_frame(input logic [15:0] e_max, input int e_idx, input bit e_nan,
                           input bit e_ovf, input int gap_max, input int hold);
    foreach (frame_q[i]) begin
      send_beat(frame_q[i], i == frame_q.size() - 1);
      if (i != frame_q.size() - 1) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk); #1;
        end
      end
    end
    check("out_valid", 64'(out_valid), 64'd1);
    check("out_max", 64'(out_max), 64'(e_max));
    check("out_index", 64'(out_index), 64'(e_idx));
    check("out_nan", 64'(out_nan), 64'(e_nan));
    check("out_ovf", 64'(out_ovf), 64'(e_ovf));
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      in_data  = 16'h7BFF;
      in_last  = 1'b1;
      @(posedge clk); #1;
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_max", 64'(out_max), 64'(e_max));
      check("hold_index", 64'(out_index), 64'(e_idx));
      check("hold_nan", 64'(out_nan), 64'(e_nan));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_ready", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    int          r;
    r = $urandom_range(0, 9);
    h = 16'($urandom);
    case (r)
      0: h = {h[15], 5'h1f, 10'($urandom_range(1, 1023))};
      1: h = {h[15], 5'h1f, 10'h000};
      2: h = {h[15], 15'h0000};
      3, 4: begin
        case ($urandom_range(0, 5))
          0: h = 16'h3C00;
          1: h = 16'h4000;
          2: h = 16'hBC00;
          3: h = 16'hC000;
          4: h = 16'h0001;
          default: h = 16'h8001;
        endcase
      end
      default: if (h[14:10] == 5'h1f) h[14:10] = 5'h1e;
    endcase
    return h;
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_max", 64'(out_max), 64'd0);
    check("rst_index", 64'(out_index), 64'd0);
    check("rst_nan", 64'(out_nan), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    frame_q = '{16'h3C00, 16'h4000, 16'hBC00};
    run_frame(16'h4000, 1, 0, 0, 0, 0);
    frame_q = '{16'hC000, 16'hBC00, 16'hFC00};
    run_frame(16'hBC00, 1, 0, 0, 0, 0);
    frame_q = '{16'h8000, 16'h0000, 16'h4000, 16'h4000};
    run_frame(16'h4000, 2, 0, 0, 0, 0);
    frame_q = '{16'h8000, 16'h0000};
    run_frame(16'h8000, 0, 0, 0, 0, 0);
    frame_q = '{16'h7E00, 16'h3C00, 16'h7C00};
    run_frame(16'h7C00, 2, 1, 0, 0, 0);
    frame_q = '{16'h7E00};
    run_frame(16'h7E00, 0, 1, 0, 0, 0);
    frame_q = '{16'h7C01, 16'hFE00};
    run_frame(16'h7E00, 0, 1, 0, 0, 0);
    frame_q = '{16'h3C00, 16'h4000};
    run_frame(16'h4000, 1, 0, 0, 0, 5);
    frame_q = '{16'h3C00};
    run_frame(16'h3C00, 0, 0, 0, 0, 0);
    frame_q = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
    run_frame(16'h4000, 0, 0, 1, 0, 0);
    frame_q = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
    run_frame(16'h4000, 3, 0, 0, 0, 0);

    // Reset in the middle of a frame
    send_beat(16'h3C00, 0);
    send_beat(16'h4000, 0);
    reset = 1'b1;
    #2;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_max", 64'(out_max), 64'd0);
    check("mid_rst_index", 64'(out_index), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    frame_q = '{16'hBC00};
    run_frame(16'hBC00, 0, 0, 0, 0, 0);

    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(1, 7);
      frame_q.delete();
      for (int k = 0; k < len; k++) frame_q.push_back(rand_half());
      model();
      run_frame(m_max, m_idx, m_nan, m_ovf, 2, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
